conv_line_feeder: RTL and testbench

Row-band pixel source for the `convolve` engine. It holds one IMG_W x IMG_H 8-bit image. It drives the three line inputs `in_l1`/`in_l2`/`in_l3`, advancing one column each cycle that `shift_buffer` is high. When the convolve engine signals `done`, it moves to the next row band (by `stride`) and restarts the engine, until the whole frame has been streamed.

---
 rtl/conv_line_feeder.sv | 164 ++++++++++++++++
 tb/tb_conv_line_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_line_feeder.sv
// Row-band pixel source for the convolve engine: holds one frame and streams three adjacent rows per band.
// Optional FEEDER_BOUNDS_CHECK_EN: saturate the column at IMG_W and flag shifts past the end as overrun.
module conv_line_feeder #(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_en,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [BIT_DEPTH-1:0] ld_data,
  input  logic                 start,
  input  logic [1:0]           stride,
  input  logic                 shift_buffer,
  input  logic                 conv_done,
  output logic [BIT_DEPTH-1:0] in_l1,
  output logic [BIT_DEPTH-1:0] in_l2,
  output logic [BIT_DEPTH-1:0] in_l3,
  output logic                 conv_start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [4:0]           band_row,
  output logic                 err,
  output logic                 overrun
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam logic [ADDR_W:0] NPIX_A = (ADDR_W + 1)'(NPIX);
`ifdef FEEDER_BOUNDS_CHECK_EN
  localparam logic [COL_W-1:0] COL_END = COL_W'(IMG_W);
`else
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_STREAM, S_ADVANCE, S_FDONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [4:0]           r_row;
  logic [COL_W-1:0]     r_col;
  logic [1:0]           r_stride;
  logic                 r_err;
  logic                 r_done_d;
  logic [BIT_DEPTH-1:0] r_mem [NPIX];

  logic                 w_stride_ok;
  logic                 w_done_rise;
  logic                 w_last_band;
  logic                 w_col_valid;
  logic                 w_pix_en;
  logic [ADDR_W-1:0]    w_addr [3];
  logic [2:0]           w_addr_ok;

  assign w_stride_ok = (stride == 2'd1) || (stride == 2'd2);
  assign w_done_rise = conv_done & ~r_done_d;
  assign w_last_band = (int'(r_row) + int'(r_stride) + 2) > (IMG_H - 1);

`ifdef FEEDER_BOUNDS_CHECK_EN
  logic r_ovr;
  assign w_col_valid = (r_col != COL_END);
  assign overrun     = r_ovr;
`else
  assign w_col_valid = 1'b1;
  assign overrun     = 1'b0;
`endif

  // Stage: combinational column read, zero latency from col/row to the line outputs
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      w_addr[n]    = ADDR_W'((int'(r_row) + n) * IMG_W + int'(r_col));
      w_addr_ok[n] = ({1'b0, w_addr[n]} < NPIX_A);
    end
  end

  assign w_pix_en = (r_state == S_STREAM) && w_col_valid;
  assign in_l1    = (w_pix_en && w_addr_ok[0]) ? r_mem[w_addr[0]] : '0;
  assign in_l2    = (w_pix_en && w_addr_ok[1]) ? r_mem[w_addr[1]] : '0;
  assign in_l3    = (w_pix_en && w_addr_ok[2]) ? r_mem[w_addr[2]] : '0;

  assign busy     = (r_state != S_IDLE);
  assign band_row = r_row;
  assign err      = r_err;

  always_ff @(posedge clk) begin
    if (ld_en && (r_state == S_IDLE) && ({1'b0, ld_addr} < NPIX_A))
      r_mem[ld_addr] <= ld_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    conv_start  = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      S_IDLE:    if (start && w_stride_ok) w_state_nxt = S_START;
      S_START: begin
        conv_start  = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM:  if (w_done_rise) w_state_nxt = S_ADVANCE;
      S_ADVANCE: w_state_nxt = w_last_band ? S_FDONE : S_START;
      S_FDONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Stage: control registers; pixel memory is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_stride <= 2'd1;
      r_err    <= 1'b0;
      r_done_d <= 1'b0;
`ifdef FEEDER_BOUNDS_CHECK_EN
      r_ovr    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_done_d <= conv_done;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_stride_ok) begin
              r_stride <= stride;
              r_row    <= '0;
              r_col    <= '0;
              r_err    <= 1'b0;
`ifdef FEEDER_BOUNDS_CHECK_EN
              r_ovr    <= 1'b0;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (shift_buffer) begin
`ifdef FEEDER_BOUNDS_CHECK_EN
            if (r_col == COL_END) r_ovr <= 1'b1;
            else                  r_col <= r_col + 1'b1;
`else
            r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
`endif
          end
        end
        S_ADVANCE: begin
          r_col <= '0;
          if (!w_last_band) r_row <= r_row + {3'b000, r_stride};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_line_feeder.sv
// Self-checking bench for conv_line_feeder: table vectors for column streaming plus band/frame sequences.
module tb_conv_line_feeder;
  localparam int BD = 8;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [BD-1:0] ld_data;
  logic          start;
  logic [1:0]    stride;
  logic          shift_buffer;
  logic          conv_done;
  logic [BD-1:0] in_l1, in_l2, in_l3;
  logic          conv_start, busy, frame_done, err, overrun;
  logic [4:0]    band_row;

  always #5 clk = ~clk;

  conv_line_feeder #(.BIT_DEPTH(BD), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .stride(stride), .shift_buffer(shift_buffer), .conv_done(conv_done),
    .in_l1(in_l1), .in_l2(in_l2), .in_l3(in_l3), .conv_start(conv_start), .busy(busy),
    .frame_done(frame_done), .band_row(band_row), .err(err), .overrun(overrun)
  );

  typedef struct {
    logic shift;
    int   l1, l2, l3;
  } vec_t;

  int n_vec  = 0;
  int n_err  = 0;
  int cs_cnt = 0;
  int fd_cnt = 0;
  int sb_q[$];
  vec_t tbl[6];

  function automatic int pix(int r, int c);
    return (r * 3 + c) % 256;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Every conv_start pops the band row the stimulus expects next
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (conv_start === 1'b1) begin
      cs_cnt++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_conv_start: band_row %0d, no band expected", band_row);
      end else begin
        chk("band_row", int'(band_row), sb_q.pop_front());
      end
    end
  end

  task automatic wait_cs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (conv_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("wait_conv_start_timeout", 0, 1);
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("wait_frame_done_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; shift_buffer = 1'b0; conv_done = 1'b0; ld_en = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    sb_q.delete();
  endtask

  task automatic start_frame(int s, int nb);
    for (int b = 0; b < nb; b++) sb_q.push_back(b * s);
    cs_cnt = 0;
    fd_cnt = 0;
    start  = 1'b1;
    stride = 2'(s);
    tick();
    start  = 1'b0;
  endtask

  // Streams three columns, then raises conv_done together with a final shift
  task automatic run_band(int row, int hold, output bit ok);
    wait_cs(ok);
    if (ok) begin
      tick();
      chk("band_col0_l1", int'(in_l1), pix(row, 0));
      chk("band_col0_l3", int'(in_l3), pix(row + 2, 0));
      shift_buffer = 1'b1;
      tick();
      tick();
      chk("band_col2_l2", int'(in_l2), pix(row + 1, 2));
      tick();
      conv_done = 1'b1;
      repeat (hold) tick();
      conv_done    = 1'b0;
      shift_buffer = 1'b0;
    end
  endtask

  task automatic run_frame(int s, int hold, int nb);
    bit ok;
    start_frame(s, nb);
    for (int b = 0; b < nb; b++) begin
      run_band(b * s, hold, ok);
      if (!ok) break;
    end
    wait_fd(ok);
    chk("busy_at_frame_done", int'(busy), 1);
    tick();
    chk("busy_after_frame", int'(busy), 0);
    chk("conv_start_count", cs_cnt, nb);
    chk("frame_done_count", fd_cnt, 1);
    chk("bands_left", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int exp;
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, i, i + 3, i + 6};
    tbl[5] = '{1'b0, 5, 8, 11};

    rst = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
    stride = 2'd1; shift_buffer = 1'b0; conv_done = 1'b0;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_conv_start", int'(conv_start), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_band_row", int'(band_row), 0);
    chk("rst_in_l1", int'(in_l1), 0);
    rst = 1'b1;

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        ld_en   = 1'b1;
        ld_addr = AW'(r * W + c);
        ld_data = BD'(pix(r, c));
        tick();
      end
    ld_en = 1'b0;

    // Invalid stride is rejected and flagged
    start  = 1'b1;
    stride = 2'd3;
    tick();
    start = 1'b0;
    chk("bad_stride_err", int'(err), 1);
    chk("bad_stride_busy", int'(busy), 0);
    repeat (3) tick();
    chk("bad_stride_err_sticky", int'(err), 1);
    chk("bad_stride_still_idle", int'(busy), 0);

    // Valid start clears err; reset in band 4
    start_frame(1, 26);
    chk("good_start_err_clr", int'(err), 0);
    for (int b = 0; b < 4; b++) run_band(b, 1, ok);
    wait_cs(ok);
    tick();
    shift_buffer = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    shift_buffer = 1'b0;
    tick();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_band_row", int'(band_row), 0);
    chk("midrst_in_l1", int'(in_l1), 0);
    chk("midrst_in_l2", int'(in_l2), 0);
    chk("midrst_conv_start", int'(conv_start), 0);
    rst = 1'b1;
    sb_q.delete();
    repeat (5) tick();

    // Table-driven column streaming after restart; a write while busy must be dropped
    start_frame(1, 1);
    chk("tbl_conv_start", int'(conv_start), 1);
    chk("tbl_busy", int'(busy), 1);
    ld_en   = 1'b1;
    ld_addr = '0;
    ld_data = 8'hAA;
    tick();
    ld_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("tbl_l1", int'(in_l1), tbl[i].l1);
      chk("tbl_l2", int'(in_l2), tbl[i].l2);
      chk("tbl_l3", int'(in_l3), tbl[i].l3);
      shift_buffer = tbl[i].shift;
      tick();
    end
    chk("tbl_hold_col5", int'(in_l1), 5);
    do_reset();

    run_frame(1, 1, 26);
    run_frame(2, 2, 13);

    // Column end behaviour
    start_frame(1, 1);
    tick();
    shift_buffer = 1'b1;
    for (int k = 1; k <= 30; k++) begin
`ifdef FEEDER_BOUNDS_CHECK_EN
      exp = (k <= W) ? pix(1, k - 1) : 0;
      if (k == 30) chk("overrun_set", int'(overrun), 1);
`else
      exp = pix(1, (k - 1) % W);
`endif
      chk("colend_l2", int'(in_l2), exp);
      tick();
    end
    shift_buffer = 1'b0;
`ifdef FEEDER_BOUNDS_CHECK_EN
    chk("overrun_final", int'(overrun), 1);
`else
    chk("overrun_final", int'(overrun), 0);
`endif
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
